// File: rtl/alu_pkg.sv
// Shared codes and defaults for the ALU accumulator sequencer slice.
package alu_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int OPW_DEF   = 3;
  localparam int CNTW_DEF  = 8;
  localparam int CCR_CARRY = 1;
  localparam int CCR_OVF   = 0;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'b00,
    CMD_EXEC = 2'b01,
    CMD_CLRF = 2'b10,
    CMD_NOP  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;
endpackage

// File: rtl/alu_acc_sequencer_sat_counter.sv
// Enabled up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/alu_acc_sequencer.sv
// Command sequencer wrapping a combinational ALU into an accumulator machine:
// IDLE accepts, ISSUE holds ALU inputs for one cycle, RESP presents the result.
module alu_acc_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic [WIDTH-1:0] alu_n1,
  output logic [WIDTH-1:0] alu_n2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_ccr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic [1:0]       out_ccr,
  output logic             out_ovf_sticky,
  output logic [CNTW-1:0]  op_count
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, n1_q, n1_d, n2_q, n2_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [1:0]       ccr_q, ccr_d;
  logic             sticky_q, sticky_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    n1_d     = n1_q;
    n2_d     = n2_q;
    op_d     = op_q;
    ccr_d    = ccr_q;
    sticky_d = sticky_q;
    case (state_q)
      S_IDLE: begin
        // in_ready_q gates acceptance so nothing is taken in the cycle after reset release
        if (in_valid && in_ready_q) begin
          state_d = S_RESP;
          case (in_cmd)
            CMD_LOAD: begin
              acc_d = in_operand;
              n1_d  = in_operand;
            end
            CMD_EXEC: begin
              n1_d    = acc_q;
              n2_d    = in_operand;
              op_d    = in_op;
              state_d = S_ISSUE;
            end
            CMD_CLRF: begin
              ccr_d    = 2'b00;
              sticky_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        acc_d    = alu_result;
        n1_d     = alu_result;
        ccr_d    = alu_ccr;
        sticky_d = sticky_q | alu_ccr[CCR_OVF];
        state_d  = S_RESP;
      end
      S_RESP: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      n1_q        <= '0;
      n2_q        <= '0;
      op_q        <= '0;
      ccr_q       <= '0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      op_q        <= op_d;
      ccr_q       <= ccr_d;
      sticky_q    <= sticky_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  sat_counter #(.W(CNTW)) u_op_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == S_ISSUE),
    .count (op_count)
  );

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_acc        = acc_q;
  assign out_ccr        = ccr_q;
  assign out_ovf_sticky = sticky_q;
  assign alu_n1         = n1_q;
  assign alu_n2         = n2_q;
  assign alu_op         = op_q;
endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Randomised bench for alu_acc_sequencer: ALU stub plus an accumulator-level reference model.
module tb_alu_acc_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [1:0] in_cmd;
  logic [2:0] in_op;
  logic [3:0] in_operand;
  logic       in_ready, out_valid, out_ovf_sticky;
  logic [3:0] alu_n1, alu_n2, alu_result, out_acc;
  logic [2:0] alu_op;
  logic [1:0] alu_ccr, out_ccr;
  logic [7:0] op_count;
  logic       in_ready2, out_valid2, out_ovf_sticky2;
  logic [3:0] alu_n1_2, alu_n2_2, alu_result2, out_acc2;
  logic [2:0] alu_op2;
  logic [1:0] alu_ccr2, out_ccr2, op_count2;

  int total = 0, bad = 0;
  int stub_mode = 0;
  logic [3:0] acc_m;
  logic [1:0] ccr_m;
  logic       sticky_m;
  logic [7:0] cnt_m;
  logic [1:0] cnt2_m;

  always #5 clk = ~clk;

  // 0: fixed 1010/01, 1: add mod 16, 2: op-dependent mini ALU
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input int mode);
    logic [4:0] s;
    logic [1:0] c;
    logic [3:0] r;
    c = 2'b00;
    if (mode == 0) return {2'b01, 4'b1010};
    if (mode == 1 || op == 3'd0) begin
      s = {1'b0, a} + {1'b0, b};
      c = {s[4], (a[3] == b[3]) && (s[3] != a[3])};
      r = s[3:0];
    end else begin
      case (op)
        3'd1: begin
          s = {1'b0, a} - {1'b0, b};
          c = {s[4], (a[3] != b[3]) && (s[3] != a[3])};
          r = s[3:0];
        end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = ~a;
        3'd6: r = b;
        default: r = a;
      endcase
    end
    return {c, r};
  endfunction

  always_comb {alu_ccr, alu_result}   = alu_f(alu_n1, alu_n2, alu_op, stub_mode);
  always_comb {alu_ccr2, alu_result2} = alu_f(alu_n1_2, alu_n2_2, alu_op2, stub_mode);

  alu_acc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_op(in_op), .in_operand(in_operand), .alu_n1(alu_n1), .alu_n2(alu_n2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_ccr(alu_ccr), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ccr(out_ccr), .out_ovf_sticky(out_ovf_sticky), .op_count(op_count));

  alu_acc_sequencer #(.CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_cmd(in_cmd),
    .in_op(in_op), .in_operand(in_operand), .alu_n1(alu_n1_2), .alu_n2(alu_n2_2), .alu_op(alu_op2),
    .alu_result(alu_result2), .alu_ccr(alu_ccr2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_acc(out_acc2), .out_ccr(out_ccr2), .out_ovf_sticky(out_ovf_sticky2), .op_count(op_count2));

  task automatic model_reset();
    acc_m = '0; ccr_m = '0; sticky_m = 1'b0; cnt_m = '0; cnt2_m = '0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // One command end to end; hold>0 keeps out_ready low for that many RESP cycles
  task automatic do_cmd(input logic [1:0] cmd, input logic [2:0] op, input logic [3:0] opnd, input int hold);
    int n = 0;
    logic [5:0] ar;
    logic [21:0] snap;
    while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
    total++;
    if (!in_ready) begin bad++; $display("FAIL wait_ready: in_ready=%b required 1", in_ready); end
    out_ready = (hold == 0);
    in_valid = 1'b1; in_cmd = cmd; in_op = op; in_operand = opnd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (cmd == 2'b01) begin
      total++;
      if ({out_valid, in_ready, alu_n1, alu_n2, alu_op} !== {2'b00, acc_m, opnd, op}) begin
        bad++;
        $display("FAIL issue_inputs: v/rdy/n1/n2/op=%b%b %h %h %h required 00 %h %h %h",
                 out_valid, in_ready, alu_n1, alu_n2, alu_op, acc_m, opnd, op);
      end
      ar = alu_f(acc_m, opnd, op, stub_mode);
      acc_m = ar[3:0]; ccr_m = ar[5:4]; sticky_m = sticky_m | ar[4];
      if (cnt_m != 8'hFF) cnt_m++;
      if (cnt2_m != 2'b11) cnt2_m++;
      @(posedge clk); #1;
    end else if (cmd == 2'b00) acc_m = opnd;
    else if (cmd == 2'b10) begin ccr_m = 2'b00; sticky_m = 1'b0; end
    snap = {1'b1, acc_m, ccr_m, sticky_m, cnt_m, cnt2_m, acc_m};
    total++;
    if ({out_valid, out_acc, out_ccr, out_ovf_sticky, op_count, op_count2, alu_n1} !== snap) begin
      bad++;
      $display("FAIL resp cmd=%b: v/acc/ccr/stk/cnt/cnt2/n1=%h required %h", cmd,
               {out_valid, out_acc, out_ccr, out_ovf_sticky, op_count, op_count2, alu_n1}, snap);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_cmd = 2'b00; in_operand = 4'($urandom);
      @(posedge clk); #1;
      total++;
      if ({in_ready, out_valid, out_acc, out_ccr, out_ovf_sticky, op_count, op_count2, alu_n1} !== {1'b0, snap}) begin
        bad++;
        $display("FAIL backpressure cyc%0d: rdy/v/acc..=%h required %h", i,
                 {in_ready, out_valid, out_acc, out_ccr, out_ovf_sticky, op_count, op_count2, alu_n1}, {1'b0, snap});
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready, out_acc} !== {2'b01, acc_m}) begin
      bad++;
      $display("FAIL resp_exit: v/rdy/acc=%b%b %h required 01 %h", out_valid, in_ready, out_acc, acc_m);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, out_valid, out_acc, out_ccr, out_ovf_sticky, op_count, alu_n1, alu_n2, alu_op} !== '0) begin
      bad++;
      $display("FAIL reset_state: outs=%h required 0",
               {in_ready, out_valid, out_acc, out_ccr, out_ovf_sticky, op_count, alu_n1, alu_n2, alu_op});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_reset_mid_exec();
    stub_mode = 2;
    do_cmd(2'b00, 3'd0, 4'b0110, 0);
    in_valid = 1'b1; in_cmd = 2'b01; in_op = 3'd0; in_operand = 4'b0011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_acc, out_ccr, out_ovf_sticky, op_count, alu_n1, alu_n2, alu_op} !== '0) begin
      bad++;
      $display("FAIL reset_mid_exec: outs=%h required 0",
               {in_ready, out_valid, out_acc, out_ccr, out_ovf_sticky, op_count, alu_n1, alu_n2, alu_op});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid, out_acc} !== {2'b10, 4'h0}) begin
      bad++;
      $display("FAIL reset_mid_exec_release: rdy/v/acc=%b%b %h required 10 0", in_ready, out_valid, out_acc);
    end
  endtask

  task automatic test_load_exec();
    stub_mode = 0;
    do_cmd(2'b00, 3'd0, 4'b0011, 0);
    do_cmd(2'b01, 3'b010, 4'b0101, 0);
    total++;
    if ({out_acc, out_ccr, out_ovf_sticky, op_count} !== {4'b1010, 2'b01, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL load_exec: acc/ccr/stk/cnt=%h %b %b %0d required a 01 1 1", out_acc, out_ccr, out_ovf_sticky, op_count);
    end
  endtask

  task automatic test_backpressure();
    do_cmd(2'b01, 3'b001, 4'b0100, 5);
  endtask

  task automatic test_clrf();
    do_cmd(2'b10, 3'd0, 4'd0, 0);
    total++;
    if ({out_acc, out_ccr, out_ovf_sticky, op_count} !== {4'b1010, 2'b00, 1'b0, 8'd2}) begin
      bad++;
      $display("FAIL clrf: acc/ccr/stk/cnt=%h %b %b %0d required a 00 0 2", out_acc, out_ccr, out_ovf_sticky, op_count);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    stub_mode = 2;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_cmd(2'b01, 3'($urandom), 4'($urandom), 0);
      total++;
      if (op_count2 !== sat_exp[k]) begin
        bad++;
        $display("FAIL saturation exec%0d: op_count=%0d required %0d", k, op_count2, sat_exp[k]);
      end
    end
  endtask

  task automatic test_chaining();
    stub_mode = 1;
    do_cmd(2'b00, 3'd0, 4'b1111, 0);
    do_cmd(2'b01, 3'd0, 4'b0001, 0);
    total++;
    if (out_acc !== 4'b0000) begin bad++; $display("FAIL chain1: acc=%h required 0", out_acc); end
    do_cmd(2'b01, 3'd0, 4'b0001, 0);
    total++;
    if (out_acc !== 4'b0001) begin bad++; $display("FAIL chain2: acc=%h required 1", out_acc); end
  endtask

  task automatic test_random();
    stub_mode = 2;
    for (int k = 0; k < 80; k++)
      do_cmd(2'($urandom), 3'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_cmd = 2'b11; in_op = '0; in_operand = '0;
    model_reset();
    #3;
    test_reset();
    test_reset_mid_exec();
    test_load_exec();
    test_backpressure();
    test_clrf();
    test_saturation();
    test_chaining();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
- Upstream control stage for the 4-bit ALU (n1, n2, 3-bit operator in; 4-bit result and 2-bit CCR {carry, overflow} out).
- Accepts commands over a valid/ready handshake and holds an accumulator that drives ALU n1; the command operand drives n2.
- Captures the ALU result and CCR back into registers, so the combinational ALU becomes a sequential accumulator machine.
- Keeps a sticky overflow flag and a saturating count of executed operations.

Parameters:
- WIDTH, 4, data width of the accumulator, operand and ALU result.
- OPW, 3, ALU operator width.
- CNTW, 8, width of the executed-operation counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid & in_ready at a rising edge.
- in_cmd  in  2  00 LOAD, 01 EXEC, 10 CLRF (clear flags), 11 NOP.
- in_op  in  OPW  ALU operator, used by EXEC only.
- in_operand  in  WIDTH  LOAD value or EXEC n2.
- alu_n1  out  WIDTH  to ALU n1; registered copy of the accumulator.
- alu_n2  out  WIDTH  to ALU n2; registered operand.
- alu_op  out  OPW  to ALU operator; registered.
- alu_result  in  WIDTH  from ALU result.
- alu_ccr  in  2  from ALU CCR, [1]=carry, [0]=overflow.
- out_valid  out  1  response valid.
- out_ready  in  1  response consumed when out_valid & out_ready at an edge.
- out_acc  out  WIDTH  accumulator value.
- out_ccr  out  2  CCR of the last EXEC.
- out_ovf_sticky  out  1  OR of all overflow bits since the last CLRF or reset.
- op_count  out  CNTW  number of completed EXECs; saturates at all-ones.

Behaviour:
- Reset (asynchronous on rst_n low; takes effect immediately, including mid-operation):
  - state = IDLE.
  - acc, alu_n1, alu_n2, alu_op, out_ccr, out_ovf_sticky, op_count all 0.
  - out_valid = 0, in_ready = 0 while rst_n is low.
  - Any in-flight command is dropped.
- FSM states: IDLE, ISSUE, RESP. in_ready = 1 only in IDLE; all other states ignore in_valid.
- IDLE, on accept:
  - LOAD: acc <= in_operand, alu_n1 <= in_operand; go to RESP.
  - EXEC: alu_n1 <= acc, alu_n2 <= in_operand, alu_op <= in_op; go to ISSUE.
  - CLRF: out_ccr <= 0, out_ovf_sticky <= 0; go to RESP.
  - NOP: go to RESP with no state change.
- ISSUE (exactly one cycle; ALU inputs are stable for the full cycle):
  - At the next edge: acc <= alu_result, alu_n1 <= alu_result, out_ccr <= alu_ccr.
  - out_ovf_sticky <= out_ovf_sticky | alu_ccr[0].
  - op_count increments unless it is all-ones.
  - Go to RESP.
- RESP:
  - out_valid = 1; out_acc, out_ccr and out_ovf_sticky are stable.
  - Leave for IDLE on the edge where out_ready = 1; out_valid falls the cycle after that edge.
  - If out_ready is already high when RESP is entered, RESP lasts exactly one cycle.
- Latency (edges from accept to out_valid high): EXEC 2; LOAD, CLRF and NOP 1.
- Throughput with out_ready held high:
  - EXEC: one command every 3 cycles (IDLE, ISSUE, RESP).
  - Other commands: one every 2 cycles.
  - Back-to-back EXECs chain through acc, so each uses the previous result as n1.
- out_acc always equals acc; alu_n1 always equals acc outside ISSUE.
- Arithmetic: the block performs none; widths must match exactly, with no extension or truncation.
- op_count wraps never: it holds at 2^CNTW-1.
- LOAD and NOP leave out_ccr unchanged.
- Undefined in_cmd bits (X) in IDLE with in_valid=1 are a bench error; RTL treats them as NOP.

Decomposition:
- Shared package alu_pkg holds:
  - command codes CMD_LOAD, CMD_EXEC, CMD_CLRF, CMD_NOP;
  - state encodings S_IDLE, S_ISSUE, S_RESP;
  - CCR bit indices CCR_CARRY=1, CCR_OVF=0;
  - default widths.
- One sub-module is natural: sat_counter (enable, saturating, width CNTW) for op_count.

Test Plan:
- Reset mid-EXEC:
  - Stimulus: accept EXEC, assert rst_n=0 during ISSUE.
  - Required: all outputs 0 immediately, in_ready=0; after release, in_ready=1 next cycle and acc=0.
- LOAD then EXEC (bench ALU stub returns result=4'b1010, ccr=2'b01):
  - Stimulus: LOAD 4'b0011, then EXEC op=3'b010 operand 4'b0101.
  - Required: alu_n1=0011, alu_n2=0101, alu_op=010 during ISSUE; out_valid 2 edges after accept; out_acc=1010, out_ccr=01, sticky=1, op_count=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after an EXEC response.
  - Required: out_valid stays 1, outputs stable, in_ready=0, a new in_valid ignored; out_ready=1 returns the block to IDLE the next cycle.
- CLRF:
  - Stimulus: after the overflow above, issue CLRF.
  - Required: out_ccr=00, sticky=0, acc unchanged at 1010, op_count unchanged.
- Saturation:
  - Stimulus: CNTW=2, issue 5 EXECs.
  - Required: op_count reads 1,2,3,3,3.
- Chaining:
  - Stimulus: stub returns alu_n1+alu_n2 mod 16; LOAD 4'b1111, then EXEC 4'b0001, EXEC 4'b0001.
  - Required: acc = 0000, then 0001; alu_n1 equals the previous acc in each ISSUE.
